data_memory_sized: RTL and testbench
====================================

# data_memory_sized

Parametrised byte-addressable data memory for the MEM stage of the pipelined MIPS core, successor to the fixed 1 KiB byte/word memory. It supports byte, halfword and word loads and stores with big-endian byte order, signed or unsigned load extension, synchronous writes, a registered one-cycle load path with a valid strobe, and detection and counting of misaligned, out-of-range and illegal accesses.

## Interface

Parameters:
- DEPTH_BYTES, 1024, memory size in bytes; power of two, at least 4
- ADDR_W, 10, log2(DEPTH_BYTES); byte-address bits actually decoded

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- MemRead  in  1  load request this cycle
- MemWrite  in  1  store request this cycle
- EXE_MEM_Size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- EXE_MEM_Unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
- EXE_MEM_Result  in  32  byte address
- EXE_MEM_Rt  in  32  store data, right-justified
- MEM_Result  out  32  load data
- MEM_Valid  out  1  one-cycle pulse: MEM_Result updated by a load
- MEM_Fault  out  1  one-cycle pulse: request this cycle was rejected
- Fault_Count  out  8  saturating count of rejected requests

## Operation

- Storage: DEPTH_BYTES x 8-bit array. Big-endian: the word at address A (A%4==0) is {mem[A], mem[A+1], mem[A+2], mem[A+3]}; a halfword at A is {mem[A], mem[A+1]}; a byte is mem[A].
- Power-on contents (initial, not reset): all zero except mem[4k+3] = (4k+4) mod 256, so word k reads 4k+4 for k < 64. rst does not alter the array.
- Request decode per cycle; a request is faulting if any of:
  - MemRead and MemWrite both 1
  - EXE_MEM_Size == 11 with MemRead or MemWrite set
  - halfword with address bit 0 set; word with address bits [1:0] nonzero
  - any of EXE_MEM_Result[31:ADDR_W] nonzero
- Faulting request: array unchanged, MEM_Result holds, MEM_Valid 0, MEM_Fault 1 for one cycle, Fault_Count increments, saturating at 255.
- Valid store: byte writes Rt[7:0]; halfword writes Rt[15:0]; word writes Rt[31:0], in the big-endian byte order above. No other bytes change.
- Valid load: the selected byte/halfword/word is extended to 32 bits according to EXE_MEM_Unsigned; word loads ignore EXE_MEM_Unsigned.
- Idle cycle (MemRead=0, MemWrite=0): no state change except that the pulses clear; MEM_Result holds.

## Timing

- Reset values: MEM_Result 0, MEM_Valid 0, MEM_Fault 0, Fault_Count 0. Asserting rst mid-stream clears these immediately. A request sampled on the edge where rst is high is discarded: no write, no count.
- Store: committed on the rising edge that samples the request.
- Load latency 1: a request in cycle N produces MEM_Result and MEM_Valid=1 during cycle N+1. Back-to-back loads produce one result per cycle.
- A store in cycle N followed by a load of the same bytes in cycle N+1 returns the new data. No same-cycle read/write forwarding is provided, because that combination is a fault.
- MEM_Valid and MEM_Fault are never both 1. Each is high for exactly one cycle per request.
- Fault_Count at 255 stays 255; MEM_Fault still pulses.

## Test plan

- Reset then load word at address 0, then address 28 -> MEM_Valid pulses in the next cycle each time, MEM_Result = 0x00000004 then 0x00000020; Fault_Count = 0.
- Store word 0x11223344 at address 8; then load byte at 8 -> 0x00000011; load unsigned byte at 11 -> 0x00000044; load halfword at 10 -> 0x00003344; load word at 8 -> 0x11223344.
- Store byte 0x80 at address 12 -> signed byte load at 12 gives 0xFFFFFF80, unsigned gives 0x00000080; load word at 12 -> 0x80000010 (byte 15 keeps 0x10).
- Faults: word load at 6, halfword store at 3, Size=11 load, load at 0x00000400, MemRead and MemWrite together -> five MEM_Fault pulses, no MEM_Valid, MEM_Result unchanged, memory unchanged, Fault_Count = 5.
- Issue 300 faulting requests -> Fault_Count stays at 255. Then assert rst asynchronously between clock edges -> all outputs 0 at once. Next load of word 8 returns the previously stored 0x11223344.
- Back-to-back loads of words 0, 4, 8 in consecutive cycles -> MEM_Valid held high for three cycles, results 0x4, 0x8, 0x11223344 in order.

Source files
------------

// File: rtl/data_memory_sized_if.sv
// Request/response bundle between the EX/MEM pipeline register and the data memory.
// The master issues loads and stores; the slave (memory) returns load data and status.
interface data_memory_sized_if;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  EXE_MEM_Size;
  logic        EXE_MEM_Unsigned;
  logic [31:0] EXE_MEM_Result;
  logic [31:0] EXE_MEM_Rt;
  logic [31:0] MEM_Result;
  logic        MEM_Valid;
  logic        MEM_Fault;
  logic [7:0]  Fault_Count;

  modport master (
    output MemRead, MemWrite, EXE_MEM_Size, EXE_MEM_Unsigned, EXE_MEM_Result, EXE_MEM_Rt,
    input  MEM_Result, MEM_Valid, MEM_Fault, Fault_Count
  );

  modport slave (
    input  MemRead, MemWrite, EXE_MEM_Size, EXE_MEM_Unsigned, EXE_MEM_Result, EXE_MEM_Rt,
    output MEM_Result, MEM_Valid, MEM_Fault, Fault_Count
  );
endinterface

// File: rtl/data_memory_sized.sv
// Big-endian byte-addressable data memory: byte/halfword/word access, registered
// one-cycle loads, and fault detection/counting for misaligned, out-of-range or illegal requests.
module data_memory_sized #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 10
) (
  input logic                 clk,
  input logic                 rst,
  data_memory_sized_if.slave  bus
);

  typedef logic [7:0] mem_t [DEPTH_BYTES];

  // Power-on image: word k holds 4k+4 in its least significant (last) byte.
  function automatic mem_t init_image();
    mem_t img;
    for (int i = 0; i < DEPTH_BYTES; i++)
      img[i] = ((i % 4) == 3) ? 8'(i + 1) : 8'h00;
    return img;
  endfunction

  mem_t mem = init_image();

  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic              req, hi_ok, align_ok, fault, do_rd, do_wr;
  logic [31:0]       ld_data;

  // Aligned accesses never carry into higher bits, so OR-ing the offset is exact.
  assign a0 = bus.EXE_MEM_Result[ADDR_W-1:0];
  assign a1 = a0 | ADDR_W'(1);
  assign a2 = a0 | ADDR_W'(2);
  assign a3 = a0 | ADDR_W'(3);

  always_comb begin
    hi_ok    = (bus.EXE_MEM_Result >> ADDR_W) == 32'd0;
    align_ok = 1'b0;
    case (bus.EXE_MEM_Size)
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~bus.EXE_MEM_Result[0];
      2'b10:   align_ok = bus.EXE_MEM_Result[1:0] == 2'b00;
      default: align_ok = 1'b0;
    endcase
    req   = bus.MemRead | bus.MemWrite;
    fault = req & ((bus.MemRead & bus.MemWrite) | ~align_ok | ~hi_ok);
    do_rd = bus.MemRead  & ~fault;
    do_wr = bus.MemWrite & ~fault;
  end

  always_comb begin
    ld_data = 32'd0;
    case (bus.EXE_MEM_Size)
      2'b00:   ld_data = {{24{~bus.EXE_MEM_Unsigned & mem[a0][7]}}, mem[a0]};
      2'b01:   ld_data = {{16{~bus.EXE_MEM_Unsigned & mem[a0][7]}}, mem[a0], mem[a1]};
      default: ld_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  // Array has no reset, but a request sampled while rst is high is dropped.
  always_ff @(posedge clk) begin
    if (!rst && do_wr) begin
      case (bus.EXE_MEM_Size)
        2'b00: mem[a0] <= bus.EXE_MEM_Rt[7:0];
        2'b01: begin
          mem[a0] <= bus.EXE_MEM_Rt[15:8];
          mem[a1] <= bus.EXE_MEM_Rt[7:0];
        end
        default: begin
          mem[a0] <= bus.EXE_MEM_Rt[31:24];
          mem[a1] <= bus.EXE_MEM_Rt[23:16];
          mem[a2] <= bus.EXE_MEM_Rt[15:8];
          mem[a3] <= bus.EXE_MEM_Rt[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.MEM_Result  <= 32'd0;
      bus.MEM_Valid   <= 1'b0;
      bus.MEM_Fault   <= 1'b0;
      bus.Fault_Count <= 8'd0;
    end else begin
      bus.MEM_Valid <= do_rd;
      bus.MEM_Fault <= fault;
      if (do_rd)
        bus.MEM_Result <= ld_data;
      if (fault && bus.Fault_Count != 8'hFF)
        bus.Fault_Count <= bus.Fault_Count + 8'd1;
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: vector table for single-cycle checks,
// hand-written sequences for saturation, asynchronous reset and back-to-back loads.
module tb_data_memory_sized;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_sized_if bus();

  data_memory_sized #(.DEPTH_BYTES(1024), .ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, rt;
    logic [31:0] res;
    logic        vld, flt;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vt[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] rt);
    bus.MemRead          = rd;
    bus.MemWrite         = wr;
    bus.EXE_MEM_Size     = size;
    bus.EXE_MEM_Unsigned = uns;
    bus.EXE_MEM_Result   = addr;
    bus.EXE_MEM_Rt       = rt;
  endtask

  task automatic add(input string nm, input logic rd, input logic wr, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr, input logic [31:0] rt,
                     input logic [31:0] res, input logic vld, input logic flt, input logic [7:0] cnt);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.rt = rt;
    v.res = res; v.vld = vld; v.flt = flt; v.cnt = cnt;
    vt.push_back(v);
  endtask

  task automatic check_out(input string nm, input logic [31:0] res, input logic vld,
                           input logic flt, input logic [7:0] cnt);
    chk({nm, ".result"}, bus.MEM_Result, res);
    chk({nm, ".valid"},  32'(bus.MEM_Valid), 32'(vld));
    chk({nm, ".fault"},  32'(bus.MEM_Fault), 32'(flt));
    chk({nm, ".count"},  32'(bus.Fault_Count), 32'(cnt));
  endtask

  initial begin
    logic [7:0] exp_cnt;

    //            name        rd wr sz   u  addr          rt            result        v  f  cnt
    add("ldw0",      1, 0, 2'b10, 0, 32'd0,        32'd0,        32'h00000004, 1, 0, 8'd0);
    add("ldw28",     1, 0, 2'b10, 0, 32'd28,       32'd0,        32'h00000020, 1, 0, 8'd0);
    add("stw8",      0, 1, 2'b10, 0, 32'd8,        32'h11223344, 32'h00000020, 0, 0, 8'd0);
    add("ldsb8",     1, 0, 2'b00, 0, 32'd8,        32'd0,        32'h00000011, 1, 0, 8'd0);
    add("ldub11",    1, 0, 2'b00, 1, 32'd11,       32'd0,        32'h00000044, 1, 0, 8'd0);
    add("ldsh10",    1, 0, 2'b01, 0, 32'd10,       32'd0,        32'h00003344, 1, 0, 8'd0);
    add("ldw8",      1, 0, 2'b10, 0, 32'd8,        32'd0,        32'h11223344, 1, 0, 8'd0);
    add("stb12",     0, 1, 2'b00, 0, 32'd12,       32'hFFFFFF80, 32'h11223344, 0, 0, 8'd0);
    add("ldsb12",    1, 0, 2'b00, 0, 32'd12,       32'd0,        32'hFFFFFF80, 1, 0, 8'd0);
    add("ldub12",    1, 0, 2'b00, 1, 32'd12,       32'd0,        32'h00000080, 1, 0, 8'd0);
    add("ldw12",     1, 0, 2'b10, 1, 32'd12,       32'd0,        32'h80000010, 1, 0, 8'd0);
    add("ldsh12",    1, 0, 2'b01, 0, 32'd12,       32'd0,        32'hFFFF8000, 1, 0, 8'd0);
    add("f_ldw6",    1, 0, 2'b10, 0, 32'd6,        32'd0,        32'hFFFF8000, 0, 1, 8'd1);
    add("f_sth3",    0, 1, 2'b01, 0, 32'd3,        32'h0000DEAD, 32'hFFFF8000, 0, 1, 8'd2);
    add("f_sz11",    1, 0, 2'b11, 0, 32'd0,        32'd0,        32'hFFFF8000, 0, 1, 8'd3);
    add("f_range",   1, 0, 2'b10, 0, 32'h00000400, 32'd0,        32'hFFFF8000, 0, 1, 8'd4);
    add("f_rdwr",    1, 1, 2'b10, 0, 32'd8,        32'h00000000, 32'hFFFF8000, 0, 1, 8'd5);
    add("idle_sz11", 0, 0, 2'b11, 0, 32'd0,        32'd0,        32'hFFFF8000, 0, 0, 8'd5);
    add("ldw8_post", 1, 0, 2'b10, 0, 32'd8,        32'd0,        32'h11223344, 1, 0, 8'd5);
    add("ldw0_post", 1, 0, 2'b10, 0, 32'd0,        32'd0,        32'h00000004, 1, 0, 8'd5);
    add("idle",      0, 0, 2'b10, 0, 32'd0,        32'd0,        32'h00000004, 0, 0, 8'd5);

    drive(0, 0, 2'b00, 0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 32'd0, 0, 0, 8'd0);
    rst = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].rd, vt[i].wr, vt[i].size, vt[i].uns, vt[i].addr, vt[i].rt);
      @(posedge clk);
      #1;
      check_out(vt[i].name, vt[i].res, vt[i].vld, vt[i].flt, vt[i].cnt);
    end

    // Saturation: 300 misaligned word loads on top of the 5 faults already counted.
    exp_cnt = 8'd5;
    for (int i = 0; i < 300; i++) begin
      drive(1, 0, 2'b10, 0, 32'd1, 32'd0);
      @(posedge clk);
      #1;
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      chk("sat.fault", 32'(bus.MEM_Fault), 32'd1);
      chk("sat.valid", 32'(bus.MEM_Valid), 32'd0);
      chk("sat.count", 32'(bus.Fault_Count), 32'(exp_cnt));
    end
    chk("sat.final", 32'(bus.Fault_Count), 32'd255);

    // Asynchronous reset between edges; a store presented while rst is high must be dropped.
    #2;
    drive(0, 1, 2'b10, 0, 32'd8, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    check_out("async_rst", 32'd0, 0, 0, 8'd0);
    @(posedge clk);
    #1;
    check_out("rst_hold", 32'd0, 0, 0, 8'd0);
    drive(0, 0, 2'b10, 0, 32'd0, 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1, 0, 2'b10, 0, 32'd8, 32'd0);
    @(posedge clk);
    #1;
    check_out("ldw8_after_rst", 32'h11223344, 1, 0, 8'd0);

    // Back-to-back word loads: one result per cycle, valid held high.
    drive(1, 0, 2'b10, 0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    check_out("b2b_0", 32'h00000004, 1, 0, 8'd0);
    drive(1, 0, 2'b10, 0, 32'd4, 32'd0);
    @(posedge clk);
    #1;
    check_out("b2b_4", 32'h00000008, 1, 0, 8'd0);
    drive(1, 0, 2'b10, 0, 32'd8, 32'd0);
    @(posedge clk);
    #1;
    check_out("b2b_8", 32'h11223344, 1, 0, 8'd0);
    drive(0, 0, 2'b10, 0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    check_out("b2b_idle", 32'h11223344, 0, 0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
